// File: rtl/pc_sequencer_if.sv
// Decoder-side bundle for the PC sequencer: controls in, PC/status out.
// Carries call/ret when PC_SEQ_CALL_EN is defined.
interface pc_sequencer_if #(
    parameter int D     = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt;
    logic             stall;
    logic             branch_en;
    logic             branch_abs;
    logic [3:0]       lut_idx;
    logic [3:0]       lut_addr;
    logic [D-1:0]     target;
    logic [D-1:0]     pc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef PC_SEQ_CALL_EN
    logic             call;
    logic             ret;

    modport master (
        output start, halt, stall, branch_en, branch_abs,
        output lut_idx, target, call, ret,
        input  lut_addr, pc, busy, done, cycle_cnt
    );

    modport slave (
        input  start, halt, stall, branch_en, branch_abs,
        input  lut_idx, target, call, ret,
        output lut_addr, pc, busy, done, cycle_cnt
    );
`else
    modport master (
        output start, halt, stall, branch_en, branch_abs,
        output lut_idx, target,
        input  lut_addr, pc, busy, done, cycle_cnt
    );

    modport slave (
        input  start, halt, stall, branch_en, branch_abs,
        input  lut_idx, target,
        output lut_addr, pc, busy, done, cycle_cnt
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: owns pc, IDLE/RUN/HALT state and the run-cycle counter.
// Optional single-level call/return via macro PC_SEQ_CALL_EN.
module pc_sequencer #(
    parameter int          D        = 10,
    parameter int unsigned START_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [D-1:0] PC_RST = D'(START_PC);

    state_e           state_q;
    logic [D-1:0]     pc_q;
    logic [D-1:0]     pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             done_q;
    logic [D-1:0]     pc_inc;
    logic [D-1:0]     pc_rel;
`ifdef PC_SEQ_CALL_EN
    logic [D-1:0]     ra_q;
    logic [D-1:0]     ra_d;
`endif

    assign pc_inc = pc_q + D'(1);
    assign pc_rel = pc_q + bus.target;

    // Counter saturates rather than wrapping.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        pc_d = pc_q;
`ifdef PC_SEQ_CALL_EN
        ra_d = ra_q;
`endif
        if (bus.halt || bus.stall) begin
            pc_d = pc_q;
`ifdef PC_SEQ_CALL_EN
        end else if (bus.ret) begin
            pc_d = ra_q;
        end else if (bus.call) begin
            ra_d = pc_inc;
            pc_d = bus.target;
`endif
        end else if (bus.branch_en) begin
            pc_d = bus.branch_abs ? bus.target : pc_rel;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PC_SEQ_CALL_EN
            ra_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        pc_q    <= PC_RST;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    pc_q  <= pc_d;
`ifdef PC_SEQ_CALL_EN
                    ra_q  <= ra_d;
`endif
                    if (bus.halt) begin
                        state_q <= S_HALT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lut_addr  = bus.lut_idx;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle model pushes expected
// pc/busy/done/cycle_cnt each cycle, popped and compared after the edge.
module tb_pc_sequencer;

    localparam int D  = 10;
    localparam int CW = 5;
    localparam int SP = 0;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [D-1:0]  pc;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.D(D), .CNT_W(CW)) bus ();

    pc_sequencer #(
        .D(D),
        .START_PC(SP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           m_st = 0;
    logic [D-1:0] m_pc = '0;
    logic [D-1:0] m_ra = '0;
    int           m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.stall      = 1'b0;
        bus.branch_en  = 1'b0;
        bus.branch_abs = 1'b0;
        bus.lut_idx    = 4'd0;
        bus.target     = '0;
`ifdef PC_SEQ_CALL_EN
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
`endif
    endtask

    // Reference model: one cycle of the specified behaviour.
    task automatic model();
        exp_t e;
        logic [D-1:0] nx;
        if (reset) begin
            m_st  = 0;
            m_pc  = D'(SP);
            m_cnt = 0;
            m_ra  = '0;
        end else if (m_st != 1) begin
            if (bus.start) begin
                m_st  = 1;
                m_pc  = D'(SP);
                m_cnt = 0;
            end
        end else begin
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            nx = m_pc + D'(1);
            if (bus.halt) m_st = 2;
            else if (bus.stall) nx = m_pc;
`ifdef PC_SEQ_CALL_EN
            else if (bus.ret) nx = m_ra;
            else if (bus.call) begin
                m_ra = m_pc + D'(1);
                nx   = bus.target;
            end
`endif
            else if (bus.branch_en && bus.branch_abs) nx = bus.target;
            else if (bus.branch_en) nx = m_pc + bus.target;
            if (!bus.halt) m_pc = nx;
        end
        e.pc   = m_pc;
        e.busy = (m_st == 1);
        e.done = (m_st == 2);
        e.cnt  = CW'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        logic [3:0] idx;
        idx = bus.lut_idx;
        model();
        #1;
        chk({tag, ".lut"}, 32'(bus.lut_addr), 32'(idx));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"}, 32'(bus.pc), 32'(e.pc));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(bus.done), 32'(e.done));
        chk({tag, ".cnt"}, 32'(bus.cycle_cnt), 32'(e.cnt));
        clr();
        @(negedge clk);
    endtask

    task automatic br(input string tag, input logic abs,
                      input logic [3:0] idx, input logic [D-1:0] tgt);
        bus.branch_en  = 1'b1;
        bus.branch_abs = abs;
        bus.lut_idx    = idx;
        bus.target     = tgt;
        step(tag);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        @(negedge clk);
        step("rst");
        reset = 1'b0;
        chk("rst.pc", 32'(bus.pc), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        step("idle");

        bus.start = 1'b1;
        step("start");
        chk("start.busy", 32'(bus.busy), 1);
        for (int i = 1; i <= 4; i++) begin
            step("inc");
            chk("seq.pc", 32'(bus.pc), 32'(i));
            chk("seq.cnt", 32'(bus.cycle_cnt), 32'(i));
        end

        br("relm1", 1'b0, 4'd1, 10'h3FF);
        chk("relm1.pc", 32'(bus.pc), 3);
        br("rel20", 1'b0, 4'd3, 10'd20);
        chk("rel20.pc", 32'(bus.pc), 23);
        br("abs5", 1'b1, 4'd7, 10'd5);
        br("abs41", 1'b1, 4'd2, 10'd41);
        chk("abs41.pc", 32'(bus.pc), 41);
        br("abs1023", 1'b1, 4'hF, 10'd1023);
        step("wrap");
        chk("wrap.pc", 32'(bus.pc), 0);

        br("abs7", 1'b1, 4'd4, 10'd7);
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1'b1;
            br("stall", 1'b1, 4'd9, 10'd99);
            chk("stall.pc", 32'(bus.pc), 7);
        end
        bus.halt = 1'b1;
        step("halt");
        chk("halt.done", 32'(bus.done), 1);
        chk("halt.pc", 32'(bus.pc), 7);
        step("hold");

        bus.start = 1'b1;
        step("restart");
        chk("restart.pc", 32'(bus.pc), 0);
        chk("restart.cnt", 32'(bus.cycle_cnt), 0);

`ifdef PC_SEQ_CALL_EN
        br("abs12", 1'b1, 4'd0, 10'd12);
        bus.call   = 1'b1;
        bus.target = 10'd72;
        step("call");
        chk("call.pc", 32'(bus.pc), 72);
        step("inc73");
        bus.ret = 1'b1;
        step("ret");
        chk("ret.pc", 32'(bus.pc), 13);
        bus.call   = 1'b1;
        bus.target = 10'd200;
        step("call2");
        bus.call   = 1'b1;
        bus.ret    = 1'b1;
        bus.target = 10'd300;
        step("both");
        chk("both.pc", 32'(bus.pc), 14);
`endif

        br("abs50", 1'b1, 4'd5, 10'd50);
        reset = 1'b1;
        step("midrst");
        reset = 1'b0;
        chk("midrst.pc", 32'(bus.pc), 0);
        chk("midrst.busy", 32'(bus.busy), 0);
        chk("midrst.done", 32'(bus.done), 0);

        bus.start = 1'b1;
        step("start2");
        for (int i = 0; i < 40; i++) step("sat");
        chk("sat.cnt", 32'(bus.cycle_cnt), 32'(CMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
